// File: rtl/probe_capture_reader_if.sv
// Byte readout channel of probe_capture_reader: valid/ready stream with an
// end-of-capture marker on the final byte.
interface probe_capture_reader_if;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       rd_last;

   modport master (
      output rd_data,
      output rd_valid,
      output rd_last,
      input  rd_ready
   );

   modport slave (
      input  rd_data,
      input  rd_valid,
      input  rd_last,
      output rd_ready
   );
endinterface

// File: rtl/probe_capture_reader.sv
// Triggered probe capture into an inferred RAM with pre-trigger history, then
// readout of the window oldest-first as three bytes per sample.
module probe_capture_reader #(
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          probe0,
   input  logic [7:0]                    probe1,
   input  logic [7:0]                    probe2,
   input  logic                          arm,
   input  logic [16:0]                   trig_mask,
   input  logic [16:0]                   trig_value,
   probe_capture_reader_if.master        rd,
   output logic                          capturing,
   output logic                          triggered,
   output logic                          done
);

   localparam int AW     = $clog2(DEPTH);
   localparam int POST_N = DEPTH - PRE_TRIG - 1;

   localparam logic [AW-1:0] FILL_LAST   = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
   localparam logic [AW-1:0] POST_LAST   = AW'((POST_N > 0) ? POST_N - 1 : 0);
   localparam logic [AW-1:0] PRE_OFS     = AW'(PRE_TRIG);
   localparam logic [AW:0]   N_SAMPLES   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LAST_SAMPLE = (AW+1)'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ARMED,
      S_POST,
      S_READOUT
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [16:0]   w_sample;
   logic          w_match;
   logic          w_we;
   logic          w_ren;
   logic [AW-1:0] w_trig_addr;

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] r_taddr;
   logic [AW-1:0] r_raddr;
   logic [AW:0]   r_issued;

   logic [16:0]   r_mem [DEPTH];
   logic [16:0]   r_ram_q;

   // Prefetch slot: r_ram_q holds the next sample once r_nxt_vld is set.
   logic          r_nxt_vld;
   logic          r_nxt_last;

   logic [15:0]   r_samp;
   logic          r_samp_last;
   logic [1:0]    r_bsel;
   logic [7:0]    r_out_data;
   logic          r_out_valid;
   logic          r_out_last;

   logic          r_capturing;
   logic          r_triggered;
   logic          r_done;

   logic          w_xfer;
   logic          w_last_xfer;
   logic          w_out_free;
   logic          w_more_bytes;
   logic          w_slot_take;

   assign w_sample     = {probe0, probe1, probe2};
   assign w_match      = (((w_sample ^ trig_value) & trig_mask) == 17'd0);

   assign w_xfer       = r_out_valid && rd.rd_ready;
   assign w_last_xfer  = w_xfer && r_out_last;
   assign w_out_free   = !r_out_valid || w_xfer;
   assign w_more_bytes = r_out_valid && (r_bsel != 2'd2);
   assign w_slot_take  = w_out_free && !w_more_bytes && r_nxt_vld;

   // State register and the registered status outputs that follow it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_capturing <= 1'b0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_capturing <= (w_state_next == S_FILL) || (w_state_next == S_ARMED) ||
                        (w_state_next == S_POST);
         r_triggered <= (w_state_next == S_POST) || (w_state_next == S_READOUT);
         r_done      <= (r_state == S_READOUT) && w_last_xfer;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (arm) begin
               w_state_next = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
            end
         end
         S_FILL: begin
            if (r_cnt == FILL_LAST) begin
               w_state_next = S_ARMED;
            end
         end
         S_ARMED: begin
            if (w_match) begin
               w_state_next = (POST_N == 0) ? S_READOUT : S_POST;
            end
         end
         S_POST: begin
            if (r_cnt == POST_LAST) begin
               w_state_next = S_READOUT;
            end
         end
         S_READOUT: begin
            if (w_last_xfer) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_we        = 1'b0;
      w_ren       = 1'b0;
      w_trig_addr = r_taddr;
      case (r_state)
         S_FILL, S_POST: w_we = 1'b1;
         S_ARMED: begin
            w_we        = 1'b1;
            w_trig_addr = r_wptr;
         end
         S_READOUT: w_ren = (r_issued != N_SAMPLES) && (!r_nxt_vld || w_slot_take);
         default: begin
            w_we  = 1'b0;
            w_ren = 1'b0;
         end
      endcase
   end

   // Pointers and counters; the read address holds the window start until
   // readout begins, so a direct ARMED->READOUT hop still sees the right base.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_cnt    <= '0;
         r_taddr  <= '0;
         r_raddr  <= '0;
         r_issued <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_wptr <= '0;
         end else if (w_we) begin
            r_wptr <= r_wptr + 1'b1;
         end

         if (w_state_next != r_state) begin
            r_cnt <= '0;
         end else if (w_we) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if ((r_state == S_ARMED) && w_match) begin
            r_taddr <= r_wptr;
         end

         if (r_state != S_READOUT) begin
            r_raddr  <= w_trig_addr - PRE_OFS;
            r_issued <= '0;
         end else if (w_ren) begin
            r_raddr  <= r_raddr + 1'b1;
            r_issued <= r_issued + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_wptr] <= w_sample;
      end
      if (w_ren) begin
         r_ram_q <= r_mem[r_raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || (r_state != S_READOUT)) begin
         r_nxt_vld   <= 1'b0;
         r_nxt_last  <= 1'b0;
         r_samp      <= '0;
         r_samp_last <= 1'b0;
         r_bsel      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_ren) begin
            r_nxt_vld  <= 1'b1;
            r_nxt_last <= (r_issued == LAST_SAMPLE);
         end else if (w_slot_take) begin
            r_nxt_vld  <= 1'b0;
         end

         if (w_out_free) begin
            if (w_more_bytes) begin
               r_bsel     <= r_bsel + 1'b1;
               r_out_data <= (r_bsel == 2'd0) ? r_samp[15:8] : r_samp[7:0];
               r_out_last <= r_samp_last && (r_bsel == 2'd1);
            end else if (r_nxt_vld) begin
               r_samp      <= r_ram_q[15:0];
               r_samp_last <= r_nxt_last;
               r_bsel      <= 2'd0;
               r_out_data  <= {7'b0, r_ram_q[16]};
               r_out_last  <= 1'b0;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end
         end
      end
   end

   assign rd.rd_data  = r_out_data;
   assign rd.rd_valid = r_out_valid;
   assign rd.rd_last  = r_out_last;
   assign capturing   = r_capturing;
   assign triggered   = r_triggered;
   assign done        = r_done;

endmodule

// File: tb/tb_probe_capture_reader.sv
// Directed bench for probe_capture_reader: probe patterns are functions of a
// cycle counter, so every expected readout byte is computed from that counter.
module tb_probe_capture_reader;
   localparam int DEPTH    = 256;
   localparam int PRE_TRIG = 32;
   localparam int NBYTES   = 3 * DEPTH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        probe0 = 1'b0;
   logic [7:0]  probe1 = 8'd0;
   logic [7:0]  probe2 = 8'd0;
   logic        arm = 1'b0;
   logic [16:0] trig_mask = 17'd0;
   logic [16:0] trig_value = 17'd0;
   logic        capturing;
   logic        triggered;
   logic        done;

   probe_capture_reader_if rd_if ();

   probe_capture_reader #(
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE_TRIG)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .probe0     (probe0),
      .probe1     (probe1),
      .probe2     (probe2),
      .arm        (arm),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .rd         (rd_if.master),
      .capturing  (capturing),
      .triggered  (triggered),
      .done       (done)
   );

   always #5 clk = ~clk;

   int         checks;
   int         failures;
   int         cyc;
   int         mode;
   logic [7:0] got [NBYTES];

   // mode 0: probe2 is the cycle counter; mode 1: probe1 is the cycle counter
   function automatic logic [16:0] pat(input int m, input int c);
      logic [7:0] v;
      v = c[7:0];
      if (m == 0) return {v[1], v ^ 8'h3C, v};
      return {v[2], v, v + 8'h40};
   endfunction

   function automatic logic [7:0] exp_byte(input int m, input int c0, input int i);
      logic [16:0] s;
      s = pat(m, c0 + i / 3);
      case (i % 3)
         0:       return {7'b0, s[16]};
         1:       return s[15:8];
         default: return s[7:0];
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, {19'b0, rd_if.rd_valid, rd_if.rd_last, capturing, triggered, done,
                  rd_if.rd_data}, 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      {probe0, probe1, probe2} = pat(mode, cyc);
   endtask

   // After an abort: outputs clear on the next cycle and no done/valid follows.
   task automatic abort_now(input string tag);
      int cnt;
      rst_n = 1'b0;
      arm   = 1'b0;
      step();
      check_idle({tag, " outputs_after_reset"});
      rst_n = 1'b1;
      rd_if.rd_ready = 1'b1;
      cnt = 0;
      repeat (8) begin
         step();
         if (done || rd_if.rd_valid || capturing) cnt++;
      end
      check({tag, " quiet_after_abort"}, cnt, 0);
   endtask

   task automatic run_capture(input string tag, input int m, input logic [16:0] msk,
                              input logic [16:0] val, input int arm_mod, input int first_off,
                              input int ready_pct, input bit poke_arm, input bit abort_post,
                              input int abort_bytes);
      int a, n, last_cnt, last_idx, done_cnt, stall_err, bad, first_bad;
      int xfer_cyc, done_cyc, t, off, extra;
      bit prev_stall, seen_valid, ended, aborted;
      logic [7:0] prev_data;
      logic prev_last;

      mode       = m;
      trig_mask  = msk;
      trig_value = val;
      while (arm_mod >= 0 && (cyc % 256) != arm_mod) step();
      a = cyc;
      arm = 1'b1;
      rd_if.rd_ready = 1'b0;
      step();

      n = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; stall_err = 0;
      xfer_cyc = 0; done_cyc = 0; t = 0;
      prev_stall = 1'b0; seen_valid = 1'b0; ended = 1'b0; aborted = 1'b0;
      prev_data = 8'd0; prev_last = 1'b0;

      while (t < 8000 && !ended) begin
         t++;
         off = cyc - a;
         arm = poke_arm && (off == 5 || off == 100 || n == 50);
         if (off == 1) check({tag, " fill_status"}, {capturing, triggered}, 2'b10);

         if (abort_post && off == 100) begin
            check({tag, " post_status_before_abort"}, {capturing, triggered}, 2'b11);
            abort_now(tag);
            aborted = 1'b1;
            ended   = 1'b1;
         end else begin
            rd_if.rd_ready = ($urandom_range(99) < ready_pct);
            if (prev_stall && (!rd_if.rd_valid || rd_if.rd_data !== prev_data ||
                               rd_if.rd_last !== prev_last)) stall_err++;
            if (rd_if.rd_valid && !seen_valid) begin
               seen_valid = 1'b1;
               check({tag, " readout_status"}, {capturing, triggered}, 2'b01);
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               ended    = 1'b1;
               check({tag, " status_at_done"}, {capturing, triggered}, 2'b00);
            end
            if (rd_if.rd_valid && rd_if.rd_ready) begin
               if (n < NBYTES) got[n] = rd_if.rd_data;
               if (rd_if.rd_last) begin
                  last_cnt++;
                  last_idx = n;
               end
               xfer_cyc = cyc;
               n++;
               if (abort_bytes > 0 && n == abort_bytes) begin
                  abort_now(tag);
                  aborted = 1'b1;
                  ended   = 1'b1;
               end
            end
            prev_stall = rd_if.rd_valid && !rd_if.rd_ready;
            prev_data  = rd_if.rd_data;
            prev_last  = rd_if.rd_last;
            if (!ended) step();
         end
      end
      check({tag, " completed_within_bound"}, {31'b0, ended}, 32'd1);
      arm = 1'b0;

      if (!aborted) begin
         bad = 0;
         first_bad = -1;
         for (int i = 0; i < NBYTES; i++) begin
            if (got[i] !== exp_byte(m, a + first_off, i)) begin
               if (bad == 0) first_bad = i;
               bad++;
            end
         end
         check({tag, " byte_count"}, n, NBYTES);
         check($sformatf("%s byte_mismatches(first=%0d)", tag, first_bad), bad, 0);
         check({tag, " last_count"}, last_cnt, 1);
         check({tag, " last_index"}, last_idx, NBYTES - 1);
         check({tag, " done_delay"}, done_cyc - xfer_cyc, 1);
         check({tag, " stall_stability_errors"}, stall_err, 0);
         extra = 0;
         rd_if.rd_ready = 1'b1;
         repeat (10) begin
            step();
            if (done || rd_if.rd_valid) extra++;
         end
         check({tag, " done_pulses"}, done_cnt + extra, 1);
         $display("capture %s: %0d bytes, trigger byte offset %0d", tag, n, 3 * PRE_TRIG);
      end
   endtask

   initial begin
      int nv;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      mode     = 0;
      rd_if.rd_ready = 1'b0;

      // Reset with random activity on the inputs
      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         {probe0, probe1, probe2} = 17'($urandom);
         arm            = 1'($urandom);
         rd_if.rd_ready = 1'($urandom);
      end
      check_idle("reset_outputs");
      rst_n = 1'b1;
      arm   = 1'b0;

      nv = 0;
      repeat (1000) begin
         step();
         rd_if.rd_ready = 1'($urandom);
         if (rd_if.rd_valid || done || capturing) nv++;
      end
      check("idle_no_activity", nv, 0);

      // Free-run trigger, mask 0: sample k carries probe2 = (11+k)&0xFF
      run_capture("freerun", 0, 17'h00000, 17'h00000, 10, 1, 100, 1'b0, 1'b0, 0);
      check("freerun sample0_probe2", {24'b0, got[2]}, 32'd11);
      check("freerun trigger_probe2", {24'b0, got[3 * PRE_TRIG + 2]}, 32'd43);
      check("freerun sample255_probe2", {24'b0, got[NBYTES - 1]}, 32'd10);

      // Masked trigger on probe1 == 0xA5, armed so that the write pointer wraps
      run_capture("masked", 1, 17'h0FF00, 17'h0A500, 133, 256, 100, 1'b0, 1'b0, 0);
      check("masked byte97", {24'b0, got[97]}, 32'h0A5);
      check("masked byte94", {24'b0, got[94]}, 32'h0A4);
      check("masked byte100", {24'b0, got[100]}, 32'h0A6);

      run_capture("backpressure", 0, 17'h00000, 17'h00000, 10, 1, 30, 1'b0, 1'b0, 0);

      run_capture("ignored_arm", 0, 17'h00000, 17'h00000, -1, 1, 100, 1'b1, 1'b0, 0);

      run_capture("abort_post", 0, 17'h00000, 17'h00000, -1, 1, 100, 1'b0, 1'b1, 0);
      run_capture("abort_readout", 0, 17'h00000, 17'h00000, -1, 1, 100, 1'b0, 1'b0, 100);

      run_capture("after_abort", 1, 17'h0FF00, 17'h0A500, 133, 256, 100, 1'b0, 1'b0, 0);
      check("after_abort byte97", {24'b0, got[97]}, 32'h0A5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/probe_capture_reader.md
# probe_capture_reader

On-chip capture buffer and byte-stream reader for the same three probe groups we route to the vendor debug core (`probe0` 1 bit, `probe1` 8 bits, `probe2` 8 bits). It records a triggered window of probe samples into an internal RAM with a pre-trigger history. It then streams the window out, oldest sample first, as bytes on a valid/ready interface. The block sits in the debug path and feeds a UART/HDMI-overlay dumper, so captures can be read without the JTAG tool.

## Interface
- `DEPTH`, 256: samples per capture; power of two, 16..1024.
- `PRE_TRIG`, 32: samples kept before the trigger sample; 0 ≤ PRE_TRIG < DEPTH.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `probe0`  in  1  probe group 0.
- `probe1`  in  8  probe group 1.
- `probe2`  in  8  probe group 2.
- `arm`  in  1  start a capture; acted on only in IDLE.
- `trig_mask`  in  17  compare mask over sample word S = {probe0, probe1, probe2}.
- `trig_value`  in  17  compare value.
- `rd_data`  out  8  readout byte.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_ready`  in  1  consumer accepts byte.
- `rd_last`  out  1  marks final byte of capture.
- `capturing`  out  1  high in FILL, ARMED and POST.
- `triggered`  out  1  high from trigger match until return to IDLE.
- `done`  out  1  one-cycle pulse after the last byte handshake.

## Operation
- States: IDLE, FILL, ARMED, POST, READOUT.
- **IDLE**
  - `arm`=1 → FILL, `wptr`←0.
  - `arm` in any other state is ignored.
- **Writing (FILL, ARMED, POST)**
  - Each cycle writes S to RAM[`wptr`], then `wptr`←`wptr`+1 mod DEPTH.
- **FILL**
  - Lasts exactly PRE_TRIG cycles; trigger compare is disabled.
  - PRE_TRIG=0 goes straight from IDLE to ARMED.
- **ARMED**
  - Match = ((S ^ `trig_value`) & `trig_mask`) == 0.
  - On match, record `taddr`=`wptr` (address of the trigger sample), set `triggered`, → POST.
  - Mask all zero matches on the first ARMED cycle.
  - ARMED may last indefinitely and wrap `wptr` any number of times.
- **POST**
  - Writes DEPTH−PRE_TRIG−1 further samples after the trigger sample, then → READOUT.
  - Start address = (`taddr` − PRE_TRIG) mod DEPTH.
- **READOUT**
  - Emits DEPTH samples from the start address upward, mod DEPTH, giving 3·DEPTH bytes.
  - Per sample: byte0 = {7'b0, probe0}, byte1 = probe1, byte2 = probe2.
  - The trigger sample is sample index PRE_TRIG, at byte offset 3·PRE_TRIG.
  - No writes in READOUT.
- **End of capture**
  - After the handshake of the byte with `rd_last`: `done`=1 for one cycle, → IDLE, `triggered`←0.
- **Reset**
  - All outputs 0, state IDLE, `wptr`/`taddr`/counters 0; RAM contents are not cleared.
  - Reset in any state, including mid-POST or mid-READOUT, aborts immediately. No `done` pulse is generated and the partial stream is abandoned.

## Timing
- `arm` high at cycle N → first write, of S at N+1, at cycle N+1.
- Trigger sample = S on the ARMED cycle in which the match is true (compare is combinational on the current S).
- Last POST write is DEPTH−PRE_TRIG−1 cycles after the trigger cycle; READOUT starts the next cycle.
- RAM read latency is 1 cycle; output registered. First `rd_valid` at most 2 cycles after READOUT entry.
- Handshake:
  - A transfer occurs when `rd_valid`&&`rd_ready`.
  - While `rd_valid`&&!`rd_ready`, `rd_data`/`rd_last` stay stable and `rd_valid` stays high.
  - `rd_valid` never drops without a transfer.
- With `rd_ready` held high, sustained throughput is 1 byte/cycle (prefetch the next sample).
- `rd_last` is high only with byte 3·DEPTH−1.
- `done` is asserted the cycle after that transfer; IDLE is reached the same cycle. `arm` is accepted from the following cycle.
- `capturing` and `triggered` are registered and change in the cycle the state changes.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with random probes/arm → all outputs 0; no `rd_valid` for 1000 cycles without `arm`.
- **Free-run trigger:** DEPTH=256, PRE_TRIG=32, mask=0, probe2 = cycle counter, `arm` at cycle 10, `rd_ready`=1 → 768 bytes. Sample k has probe2 = (11+k)&0xFF. `rd_last` only on byte 767; one `done`.
- **Masked trigger:** mask=0x0FF00, value=0x0A500, probe1 = counter → byte at offset 97 = 0xA5. Bytes 94 and 100 = 0xA4 and 0xA6. Trigger wraps RAM; samples stay contiguous.
- **Backpressure:** random 30% `rd_ready` → byte sequence identical to the no-stall run. `rd_data` stable during every stall; no drop or duplicate.
- **Ignored arm:** pulse `arm` during FILL, POST and READOUT → no restart, identical output. After `done`, a new `arm` starts a fresh capture.
- **Mid-operation reset:** assert `rst_n`=0 mid-POST and mid-READOUT (after 100 bytes) → next cycle all outputs 0, state IDLE, no `done`. A subsequent capture is correct.
